// File: rtl/seg_marquee_counter_if.sv
// Control and display bundle for seg_marquee_counter.
// The master side drives the controls; the counter (slave) drives the display outputs.
interface seg_marquee_counter_if #(
  parameter int DIGITS = 8
);
  localparam int POS_W = $clog2(DIGITS);

  logic              en;
  logic              dis_dir;
  logic              cnt_updn;
  logic              bounce;
  logic [2:0]        speed;
  logic              load;
  logic [3:0]        load_val;
  logic [DIGITS-1:0] out_dis;
  logic [6:0]        out_num;
  logic [POS_W-1:0]  pos;
  logic [3:0]        cnt;
  logic              wrap;

  modport master (
    output en, dis_dir, cnt_updn, bounce, speed, load, load_val,
    input  out_dis, out_num, pos, cnt, wrap
  );

  modport slave (
    input  en, dis_dir, cnt_updn, bounce, speed, load, load_val,
    output out_dis, out_num, pos, cnt, wrap
  );
endinterface

// File: rtl/seg_marquee_counter.sv
// Scanning seven-segment counter: one lit digit walks the display bank and each
// full pass (or bounce turnaround) steps a modulo-(CNT_MAX+1) count.
module seg_marquee_counter #(
  parameter int DIGITS     = 8,
  parameter int BASE_SHIFT = 26,
  parameter int CNT_MAX    = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  seg_marquee_counter_if.slave  bus
);
  localparam int                    POS_W     = $clog2(DIGITS);
  localparam logic [POS_W-1:0]      POS_LAST  = POS_W'(DIGITS - 1);
  localparam logic [3:0]            CNT_TOP   = 4'(CNT_MAX);
  localparam logic [BASE_SHIFT-1:0] MASK_FULL = '1;

  logic [BASE_SHIFT-1:0] pre_q, pre_d;
  logic [BASE_SHIFT-1:0] tick_mask;
  logic [POS_W-1:0]      pos_q, pos_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  hdir_q, hdir_d;
  logic                  wrap_q, wrap_d;
  logic                  tick;
  logic                  step;
  logic [6:0]            seg;

  // Speed only narrows the prescaler compare window, so a change lands on the next natural tick.
  always_comb begin
    tick_mask = MASK_FULL;
    case (bus.speed)
      3'b001:  tick_mask = MASK_FULL >> 1;
      3'b010:  tick_mask = MASK_FULL >> 2;
      3'b100:  tick_mask = MASK_FULL >> 3;
      default: tick_mask = MASK_FULL;
    endcase
  end

  assign tick = bus.en && ((pre_q & tick_mask) == tick_mask);

  always_comb begin
    pre_d  = pre_q;
    pos_d  = pos_q;
    cnt_d  = cnt_q;
    hdir_d = hdir_q;
    step   = 1'b0;

    if (bus.en)
      pre_d = pre_q + 1'b1;
    if (!bus.bounce)
      hdir_d = bus.dis_dir;

    if (tick) begin
      if (!bus.bounce) begin
        if (bus.dis_dir) begin
          if (pos_q == POS_LAST) begin
            pos_d = '0;
            step  = 1'b1;
          end else begin
            pos_d = pos_q + 1'b1;
          end
        end else begin
          if (pos_q == '0) begin
            pos_d = POS_LAST;
            step  = 1'b1;
          end else begin
            pos_d = pos_q - 1'b1;
          end
        end
      end else begin
        // Bounce: at an end, turn around and move one step back inward.
        if (hdir_q) begin
          if (pos_q == POS_LAST) begin
            hdir_d = 1'b0;
            pos_d  = pos_q - 1'b1;
            step   = 1'b1;
          end else begin
            pos_d = pos_q + 1'b1;
          end
        end else begin
          if (pos_q == '0) begin
            hdir_d = 1'b1;
            pos_d  = pos_q + 1'b1;
            step   = 1'b1;
          end else begin
            pos_d = pos_q - 1'b1;
          end
        end
      end
    end

    if (step) begin
      if (bus.cnt_updn)
        cnt_d = (cnt_q == CNT_TOP) ? 4'd0 : cnt_q + 4'd1;
      else
        cnt_d = (cnt_q == 4'd0) ? CNT_TOP : cnt_q - 4'd1;
    end
    wrap_d = step;

    // Load overrides any tick that happens in the same cycle.
    if (bus.load) begin
      cnt_d  = (bus.load_val > CNT_TOP) ? CNT_TOP : bus.load_val;
      pos_d  = bus.dis_dir ? '0 : POS_LAST;
      hdir_d = bus.dis_dir;
      pre_d  = '0;
      wrap_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_q  <= '0;
      pos_q  <= '0;
      cnt_q  <= '0;
      hdir_q <= 1'b1;
      wrap_q <= 1'b0;
    end else begin
      pre_q  <= pre_d;
      pos_q  <= pos_d;
      cnt_q  <= cnt_d;
      hdir_q <= hdir_d;
      wrap_q <= wrap_d;
    end
  end

  always_comb begin
    seg = 7'b1111111;
    case (cnt_q)
      4'd0:  seg = 7'b0000001;
      4'd1:  seg = 7'b1001111;
      4'd2:  seg = 7'b0010010;
      4'd3:  seg = 7'b0000110;
      4'd4:  seg = 7'b1001100;
      4'd5:  seg = 7'b0100100;
      4'd6:  seg = 7'b1100000;
      4'd7:  seg = 7'b0001111;
      4'd8:  seg = 7'b0000000;
      4'd9:  seg = 7'b0001100;
      4'd10: seg = 7'b1110010;
      4'd11: seg = 7'b1100110;
      4'd12: seg = 7'b1011100;
      4'd13: seg = 7'b0110100;
      4'd14: seg = 7'b1110000;
      4'd15: seg = 7'b1111111;
      default: seg = 7'b1111111;
    endcase
  end

  // Digit position 0 maps to the most significant enable bit.
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_dis
    assign bus.out_dis[gi] = (pos_q != POS_W'(DIGITS - 1 - gi));
  end

  assign bus.out_num = seg;
  assign bus.pos     = pos_q;
  assign bus.cnt     = cnt_q;
  assign bus.wrap    = wrap_q;
endmodule
